spram_rr_arbiter: RTL and testbench

- Shares one single-port 1024x32 SPRAM (address/wren/data/out) between NUM_REQ independent requesters.
- Uses round-robin arbitration, one access per cycle.
- Registers the winning command into the memory and routes read data back to the winning requester with a valid strobe.
- Sits between compute engines (activation units, systolic-array loaders) and the shared on-chip buffer.

---
 rtl/spram_rr_arbiter_pkg.sv | 42 ++++
 rtl/spram_rr_arbiter_rr_priority_select.sv | 30 +++
 rtl/spram_rr_arbiter.sv | 103 ++++++++++
 tb/tb_spram_rr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_rr_arbiter_pkg.sv
// rtl/spram_rr_arbiter_pkg.sv - shared constants, return-tag record and round-robin search helper
package spram_rr_arbiter_pkg;

  localparam int NUM_REQ_DEF      = 4;
  localparam int ADDR_WIDTH_DEF   = 10;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int READ_LATENCY_DEF = 1;
  localparam int PIPE_DEPTH       = 1 + READ_LATENCY_DEF;
  localparam int MAX_REQ          = 8;
  localparam int IDX_W            = 3;

  // One slot of the read-return pipeline; idx is one-hot, sized for the largest requester count.
  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] idx;
  } rd_tag_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } rr_result_t;

  // Scans from ptr upward modulo n; iterating downward lets the closest hit overwrite farther ones.
  function automatic rr_result_t rr_index(input logic [IDX_W-1:0] ptr,
                                          input logic [MAX_REQ-1:0] req,
                                          input int n);
    rr_result_t r;
    int         idx;
    r = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (int'(ptr) + k) % n;
        if (req[idx[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.index = idx[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/spram_rr_arbiter_rr_priority_select.sv
// rtl/spram_rr_arbiter_rr_priority_select.sv - combinational rotating-priority grant selection
module rr_priority_select
  import spram_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   winner,
  output logic               any_gnt
);

  logic [MAX_REQ-1:0] req_ext;
  rr_result_t         res;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req;
    res                    = rr_index(IDX_W'(ptr), req_ext, NUM_REQ);
    gnt                    = '0;
    winner                 = res.index[PTR_W-1:0];
    any_gnt                = res.found;
    if (res.found) begin
      gnt[res.index[PTR_W-1:0]] = 1'b1;
    end
  end

endmodule

// File: rtl/spram_rr_arbiter.sv
// rtl/spram_rr_arbiter.sv - round-robin sharing of one single-port SPRAM with tagged read return
module spram_rr_arbiter
  import spram_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wren,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rd_valid,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_wren,
  output logic [DATA_WIDTH-1:0]         mem_data,
  input  logic [DATA_WIDTH-1:0]         mem_out
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int PIPE_D = 1 + READ_LATENCY;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      winner;
  logic                  any_gnt;
  logic [NUM_REQ-1:0]    sel_gnt;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  win_wren;
  logic [DATA_WIDTH-1:0] rd_data_q;
  rd_tag_t               tag_in;
  rd_tag_t               tag_pipe [PIPE_D];

  rr_priority_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_sel (
    .req     (req),
    .ptr     (ptr),
    .gnt     (sel_gnt),
    .winner  (winner),
    .any_gnt (any_gnt)
  );

  // Grant is forced low while reset is held so no requester believes its command was taken.
  assign gnt = reset ? sel_gnt : '0;

  always_comb begin
    win_addr      = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
    win_data      = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    win_wren      = req_wren[winner];
    tag_in        = '0;
    tag_in.valid  = any_gnt & ~win_wren;
    tag_in.idx    = MAX_REQ'(sel_gnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr         <= '0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else if (any_gnt) begin
      ptr         <= (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      mem_address <= win_addr;
      mem_data    <= win_data;
      mem_wren    <= win_wren;
    end else begin
      mem_wren    <= 1'b0;
    end
  end

  // Tags advance one stage per cycle; the last stage lines up with mem_out for that read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE_D; i++) begin
        tag_pipe[i] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      tag_pipe[0] <= tag_in;
      for (int i = 1; i < PIPE_D; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
      rd_data_q <= rd_data;
    end
  end

  assign rd_valid = tag_pipe[PIPE_D-1].valid ? tag_pipe[PIPE_D-1].idx[NUM_REQ-1:0] : '0;

  always_comb begin
    rd_data = rd_data_q;
    if (|rd_valid) begin
      rd_data = mem_out;
    end
  end

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// tb/tb_spram_rr_arbiter.sv - directed bench with a queue-based reference model of the arbiter
module tb_spram_rr_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  req_wren;
  logic [39:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  rd_valid;
  logic [31:0] rd_data;
  logic [9:0]  mem_address;
  logic        mem_wren;
  logic [31:0] mem_data;
  logic [31:0] mem_out;

  spram_rr_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_wren    (req_wren),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .gnt         (gnt),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .mem_address (mem_address),
    .mem_wren    (mem_wren),
    .mem_data    (mem_data),
    .mem_out     (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SPRAM: write-then-read order, one cycle read latency.
  logic [31:0] spram [1024];
  always @(posedge clk) begin
    if (mem_wren) spram[mem_address] <= mem_data;
    mem_out <= spram[mem_address];
  end

  typedef struct {
    int          due;
    logic [3:0]  oh;
    logic [31:0] d;
  } ret_t;

  ret_t        retq[$];
  logic [31:0] ref_mem [1024];
  int          ptr_m;
  int          cyc;
  logic        exp_wren;
  logic [9:0]  exp_addr;
  logic [31:0] exp_data;
  logic [31:0] exp_rd_data;
  int          n_chk;
  int          n_fail;
  logic [3:0]  obs_gnt;
  logic [3:0]  obs_rv;
  logic [31:0] obs_rd;
  logic        obs_wren;
  logic [9:0]  obs_addr;
  logic [3:0]  g_log [16];
  logic [3:0]  rv_log [16];
  logic [31:0] rd_log [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_cmd(input int i, input logic wr, input logic [9:0] a, input logic [31:0] d);
    req[i]             = 1'b1;
    req_wren[i]        = wr;
    req_addr[i*10 +: 10] = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic clr_req();
    req      = '0;
    req_wren = '0;
  endtask

  // Compares the DUT against the model at the falling edge, then advances the model by one cycle.
  task automatic tick();
    int         w;
    logic [3:0] eg;
    logic [3:0] erv;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      ptr_m = 0;
      retq.delete();
      exp_wren = 1'b0;
      exp_addr = '0;
      exp_data = '0;
      exp_rd_data = '0;
      chk("rst_gnt", 64'(gnt), 64'h0);
      chk("rst_rd_valid", 64'(rd_valid), 64'h0);
      chk("rst_rd_data", 64'(rd_data), 64'h0);
      chk("rst_mem_wren", 64'(mem_wren), 64'h0);
      chk("rst_mem_address", 64'(mem_address), 64'h0);
      chk("rst_mem_data", 64'(mem_data), 64'h0);
    end else begin
      w = -1;
      for (int k = 3; k >= 0; k--) begin
        if (req[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      end
      eg = (w >= 0) ? 4'(1 << w) : 4'h0;
      erv = 4'h0;
      if (retq.size() > 0 && retq[0].due == cyc) begin
        erv = retq[0].oh;
        exp_rd_data = retq[0].d;
        void'(retq.pop_front());
      end
      chk("gnt", 64'(gnt), 64'(eg));
      chk("rd_valid", 64'(rd_valid), 64'(erv));
      chk("rd_data", 64'(rd_data), 64'(exp_rd_data));
      chk("mem_wren", 64'(mem_wren), 64'(exp_wren));
      chk("mem_address", 64'(mem_address), 64'(exp_addr));
      chk("mem_data", 64'(mem_data), 64'(exp_data));
      if (w >= 0) begin
        ptr_m    = (w + 1) % 4;
        exp_addr = req_addr[w*10 +: 10];
        exp_data = req_data[w*32 +: 32];
        exp_wren = req_wren[w];
        if (req_wren[w]) ref_mem[exp_addr] = exp_data;
        else retq.push_back('{cyc + 2, 4'(1 << w), ref_mem[exp_addr]});
      end else begin
        exp_wren = 1'b0;
      end
    end
    obs_gnt  = gnt;
    obs_rv   = rd_valid;
    obs_rd   = rd_data;
    obs_wren = mem_wren;
    obs_addr = mem_address;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    n_chk = 0; n_fail = 0; cyc = 0; ptr_m = 0;
    exp_wren = 0; exp_addr = 0; exp_data = 0; exp_rd_data = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    reset = 1'b0; req = '0; req_wren = '0; req_addr = '0; req_data = '0;
    @(posedge clk); #1;
    tick(); tick();
    reset = 1'b1;

    // Preload through requester 3 so the pointer ends back at 0.
    for (int k = 0; k < 16; k++) begin
      clr_req();
      set_cmd(3, 1'b1, 10'(k), 32'h1000_0000 + k);
      tick();
      chk("preload_gnt", 64'(obs_gnt), 64'h8);
    end

    // Round robin, all four reading.
    for (int k = 0; k < 10; k++) begin
      clr_req();
      if (k < 8) for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 10'(k), 32'h0);
      tick();
      g_log[k] = obs_gnt; rv_log[k] = obs_rv; rd_log[k] = obs_rd;
    end
    for (int k = 0; k < 8; k++) begin
      chk("rr_gnt_seq", 64'(g_log[k]), 64'(4'b0001 << (k % 4)));
      chk("rr_rd_valid_seq", 64'(rv_log[k+2]), 64'(4'b0001 << (k % 4)));
    end
    chk("rr_rd_data_k5", 64'(rd_log[7]), 64'h1000_0005);

    // Write 0xDEADBEEF via requester 1, read it back via requester 2.
    clr_req(); set_cmd(1, 1'b1, 10'h2A, 32'hDEADBEEF); tick();
    chk("wtr_wr_gnt", 64'(obs_gnt), 64'h2);
    clr_req(); set_cmd(2, 1'b0, 10'h2A, 32'h0); tick();
    chk("wtr_rd_gnt", 64'(obs_gnt), 64'h4);
    clr_req(); tick(); tick();
    chk("wtr_rd_valid", 64'(obs_rv), 64'h4);
    chk("wtr_rd_data", 64'(obs_rd), 64'hDEADBEEF);

    // Idle, then a single requester streaming reads.
    clr_req();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_gnt", 64'(obs_gnt), 64'h0);
      chk("idle_mem_wren", 64'(obs_wren), 64'h0);
    end
    for (int k = 0; k < 6; k++) begin
      clr_req();
      if (k < 4) set_cmd(3, 1'b0, 10'(k + 8), 32'h0);
      tick();
      g_log[k] = obs_gnt; rv_log[k] = obs_rv; rd_log[k] = obs_rd;
    end
    for (int k = 0; k < 4; k++) begin
      chk("single_gnt", 64'(g_log[k]), 64'h8);
      chk("single_rd_valid", 64'(rv_log[k+2]), 64'h8);
    end
    chk("single_rd_data", 64'(rd_log[5]), 64'h1000_000B);

    // Fairness: requester 0 always requesting, requester 3 raises once.
    clr_req(); set_cmd(0, 1'b0, 10'd1, 32'h0); set_cmd(3, 1'b0, 10'd2, 32'h0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!obs_gnt[3] && n < 6);
    chk("fair_req3_latency_ok", 64'(n <= 3), 64'h1);
    clr_req(); set_cmd(0, 1'b0, 10'd1, 32'h0); set_cmd(3, 1'b0, 10'd2, 32'h0);
    tick();
    chk("fair_ptr_back_to_0", 64'(obs_gnt), 64'h1);
    clr_req(); tick(); tick();

    // Address boundary: top and bottom of the array through requester 2.
    for (int k = 0; k < 7; k++) begin
      clr_req();
      case (k)
        0: set_cmd(2, 1'b1, 10'h3FF, 32'hA5A5_0001);
        1: set_cmd(2, 1'b1, 10'h000, 32'h5A5A_0002);
        2: set_cmd(2, 1'b0, 10'h3FF, 32'h0);
        3: set_cmd(2, 1'b0, 10'h000, 32'h0);
        default: ;
      endcase
      tick();
      rv_log[k] = obs_rv; rd_log[k] = obs_rd;
    end
    chk("wrap_rv_3ff", 64'(rv_log[4]), 64'h4);
    chk("wrap_data_3ff", 64'(rd_log[4]), 64'hA5A5_0001);
    chk("wrap_data_000", 64'(rd_log[5]), 64'h5A5A_0002);

    // Reset with a read in flight; the read must never be reported.
    clr_req(); set_cmd(1, 1'b0, 10'd4, 32'h0); tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midrst_rd_valid", 64'(obs_rv), 64'h0);
      chk("midrst_mem_address", 64'(obs_addr), 64'h0);
    end
    reset = 1'b1;
    clr_req();
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b0, 10'd6, 32'h0);
    tick();
    chk("post_rst_first_gnt", 64'(obs_gnt), 64'h1);
    clr_req();
    for (int k = 0; k < 4; k++) tick();
    chk("model_drained", 64'(retq.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
